// File: rtl/tl_rx_fc_pkg.sv
// Shared encodings for the RX flow-control credit capture block.
package tl_rx_fc_pkg;

  typedef enum logic [1:0] {
    FC_TYPE_P    = 2'b00,
    FC_TYPE_NP   = 2'b01,
    FC_TYPE_CPL  = 2'b10,
    FC_TYPE_RSVD = 2'b11
  } fc_type_e;

  typedef enum logic [1:0] {
    FC_KIND_INIT1  = 2'b00,
    FC_KIND_INIT2  = 2'b01,
    FC_KIND_UPDATE = 2'b10,
    FC_KIND_RSVD   = 2'b11
  } fc_kind_e;

  typedef enum logic [1:0] {
    FC_INIT1  = 2'b00,
    FC_INIT2  = 2'b01,
    FC_ACTIVE = 2'b10
  } fc_state_e;

  localparam int FC_NUM_TYPES = 3;

endpackage

// File: rtl/tl_rx_fc_credit_capture_if.sv
// DLL flow-control packet bundle; master is the DLL side, slave the credit capture block.
interface tl_rx_fc_credit_capture_if #(
  parameter int HDR_W  = 12,
  parameter int DATA_W = 16
);
  logic              dll_valid;
  logic [1:0]        dll_fc_type;
  logic [1:0]        dll_fc_kind;
  logic [HDR_W-1:0]  dll_hdr_creds;
  logic [DATA_W-1:0] dll_data_creds;
  logic [1:0]        dll_hdr_scale;
  logic [1:0]        dll_data_scale;

  modport master (
    output dll_valid, dll_fc_type, dll_fc_kind,
           dll_hdr_creds, dll_data_creds, dll_hdr_scale, dll_data_scale
  );

  modport slave (
    input  dll_valid, dll_fc_type, dll_fc_kind,
           dll_hdr_creds, dll_data_creds, dll_hdr_scale, dll_data_scale
  );
endinterface

// File: rtl/tl_rx_fc_type_regs.sv
// Per-FC-type credit/scale store: first capture_en wins, update_en refreshes non-infinite credits.
module tl_rx_fc_type_regs #(
  parameter int HDR_W  = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              capture_en_i,
  input  logic              update_en_i,
  input  logic [HDR_W-1:0]  hdr_creds_i,
  input  logic [DATA_W-1:0] data_creds_i,
  input  logic [1:0]        hdr_scale_i,
  input  logic [1:0]        data_scale_i,
  output logic [HDR_W-1:0]  hdr_creds_o,
  output logic [DATA_W-1:0] data_creds_o,
  output logic [1:0]        hdr_scale_o,
  output logic [1:0]        data_scale_o,
  output logic              hdr_inf_o,
  output logic              data_inf_o,
  output logic              got_o
);

  logic [HDR_W-1:0]  hdr_q,  hdr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        hscale_q, hscale_d, dscale_q, dscale_d;
  logic              hinf_q, hinf_d, dinf_q, dinf_d, got_q, got_d;

  always_comb begin
    hdr_d    = hdr_q;
    data_d   = data_q;
    hscale_d = hscale_q;
    dscale_d = dscale_q;
    hinf_d   = hinf_q;
    dinf_d   = dinf_q;
    got_d    = got_q;
    if (capture_en_i && !got_q) begin
      hdr_d    = hdr_creds_i;
      data_d   = data_creds_i;
      hscale_d = hdr_scale_i;
      dscale_d = data_scale_i;
      hinf_d   = (hdr_creds_i == '0);
      dinf_d   = (data_creds_i == '0);
      got_d    = 1'b1;
    end else if (update_en_i) begin
      // Infinite fields were advertised as 0 and must never become finite.
      if (!hinf_q) hdr_d  = hdr_creds_i;
      if (!dinf_q) data_d = data_creds_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      hdr_q    <= '0;
      data_q   <= '0;
      hscale_q <= 2'b00;
      dscale_q <= 2'b00;
      hinf_q   <= 1'b0;
      dinf_q   <= 1'b0;
      got_q    <= 1'b0;
    end else begin
      hdr_q    <= hdr_d;
      data_q   <= data_d;
      hscale_q <= hscale_d;
      dscale_q <= dscale_d;
      hinf_q   <= hinf_d;
      dinf_q   <= dinf_d;
      got_q    <= got_d;
    end
  end

  assign hdr_creds_o  = hdr_q;
  assign data_creds_o = data_q;
  assign hdr_scale_o  = hscale_q;
  assign data_scale_o = dscale_q;
  assign hdr_inf_o    = hinf_q;
  assign data_inf_o   = dinf_q;
  assign got_o        = got_q;

endmodule

// File: rtl/tl_rx_fc_credit_capture.sv
// Captures link-partner FC credits/scales per type and runs the INIT1 -> INIT2 -> ACTIVE handshake.
// Outputs to the checker are a mux of stored registers only, selected by dll_fc_type.
module tl_rx_fc_credit_capture
  import tl_rx_fc_pkg::*;
#(
  parameter int FC_DATA_CREDS_WIDTH  = 16,
  parameter int FC_HDR_CREDS_WIDTH   = 12,
  parameter int DLL_DATA_CREDS_WIDTH = 16,
  parameter int DLL_HDR_CREDS_WIDTH  = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           dll_link_up,
  tl_rx_fc_credit_capture_if.slave       dll,
  input  logic                           flow_control_error,
  output logic [FC_HDR_CREDS_WIDTH-1:0]  hdr_creds_reg,
  output logic [FC_DATA_CREDS_WIDTH-1:0] data_creds_reg,
  output logic [1:0]                     hdr_scale_reg,
  output logic [1:0]                     data_scale_reg,
  output logic                           flow_control_en,
  output logic                           fc_init_done,
  output logic [2:0]                     hdr_infinite,
  output logic [2:0]                     data_infinite,
  output logic                           fc_protocol_error
);

  localparam int HEXT = (DLL_HDR_CREDS_WIDTH > FC_HDR_CREDS_WIDTH) ? DLL_HDR_CREDS_WIDTH : FC_HDR_CREDS_WIDTH;
  localparam int DEXT = (DLL_DATA_CREDS_WIDTH > FC_DATA_CREDS_WIDTH) ? DLL_DATA_CREDS_WIDTH : FC_DATA_CREDS_WIDTH;

  fc_state_e state_q, state_d;
  logic      en_q, err_q, err_d;
  logic      clr;
  logic      pkt_legal;
  logic [FC_NUM_TYPES-1:0] type_sel, capture_en, update_en, got, hinf, dinf;

  logic [HEXT-1:0]                hdr_ext;
  logic [DEXT-1:0]                data_ext;
  logic [FC_HDR_CREDS_WIDTH-1:0]  hdr_conv;
  logic [FC_DATA_CREDS_WIDTH-1:0] data_conv;

  logic [FC_HDR_CREDS_WIDTH-1:0]  hdr_arr    [FC_NUM_TYPES];
  logic [FC_DATA_CREDS_WIDTH-1:0] data_arr   [FC_NUM_TYPES];
  logic [1:0]                     hscale_arr [FC_NUM_TYPES];
  logic [1:0]                     dscale_arr [FC_NUM_TYPES];

  assign clr       = !dll_link_up;
  assign hdr_ext   = HEXT'(dll.dll_hdr_creds);
  assign data_ext  = DEXT'(dll.dll_data_creds);
  assign hdr_conv  = hdr_ext[FC_HDR_CREDS_WIDTH-1:0];
  assign data_conv = data_ext[FC_DATA_CREDS_WIDTH-1:0];
  assign pkt_legal = dll.dll_valid && (dll.dll_fc_type != FC_TYPE_RSVD);

  for (genvar i = 0; i < FC_NUM_TYPES; i++) begin : g_type
    assign type_sel[i]   = pkt_legal && (dll.dll_fc_type == 2'(i));
    assign capture_en[i] = type_sel[i] && (state_q == FC_INIT1) && (dll.dll_fc_kind == FC_KIND_INIT1);
    assign update_en[i]  = type_sel[i] && (state_q == FC_ACTIVE) && (dll.dll_fc_kind == FC_KIND_UPDATE)
                           && !flow_control_error;

    tl_rx_fc_type_regs #(
      .HDR_W  (FC_HDR_CREDS_WIDTH),
      .DATA_W (FC_DATA_CREDS_WIDTH)
    ) u_regs (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (clr),
      .capture_en_i (capture_en[i]),
      .update_en_i  (update_en[i]),
      .hdr_creds_i  (hdr_conv),
      .data_creds_i (data_conv),
      .hdr_scale_i  (dll.dll_hdr_scale),
      .data_scale_i (dll.dll_data_scale),
      .hdr_creds_o  (hdr_arr[i]),
      .data_creds_o (data_arr[i]),
      .hdr_scale_o  (hscale_arr[i]),
      .data_scale_o (dscale_arr[i]),
      .hdr_inf_o    (hinf[i]),
      .data_inf_o   (dinf[i]),
      .got_o        (got[i])
    );
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      FC_INIT1:  if (&got) state_d = FC_INIT2;
      FC_INIT2:  if (pkt_legal && dll.dll_fc_kind == FC_KIND_INIT2) state_d = FC_ACTIVE;
      FC_ACTIVE: begin
        if (pkt_legal && dll.dll_fc_kind == FC_KIND_UPDATE && flow_control_error) err_d = 1'b1;
      end
      default:   state_d = FC_INIT1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= FC_INIT1;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= (state_d == FC_ACTIVE);
      err_q   <= err_d;
    end
  end

  // Select is the packet type only; credit values come from registers, never from dll_* credits.
  always_comb begin
    hdr_creds_reg  = '0;
    data_creds_reg = '0;
    hdr_scale_reg  = 2'b00;
    data_scale_reg = 2'b00;
    case (dll.dll_fc_type)
      FC_TYPE_P, FC_TYPE_NP, FC_TYPE_CPL: begin
        hdr_creds_reg  = hdr_arr[dll.dll_fc_type];
        data_creds_reg = data_arr[dll.dll_fc_type];
        hdr_scale_reg  = hscale_arr[dll.dll_fc_type];
        data_scale_reg = dscale_arr[dll.dll_fc_type];
      end
      default: ;
    endcase
  end

  assign flow_control_en   = en_q;
  assign fc_init_done      = en_q;
  assign hdr_infinite      = hinf;
  assign data_infinite     = dinf;
  assign fc_protocol_error = err_q;

endmodule
